// File: rtl/myddr_axil_slave.sv
// rtl/myddr_axil_slave.sv - AXI4-Lite responder with four 32-bit byte-strobed registers
module myddr_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                          aw_full;
    logic                          w_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic unused_ok;

    // Anything decoded above the four-register window is an error response.
    function automatic logic in_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (a >> 4) == '0;
    endfunction

    assign S_AXI_AWREADY = !aw_full && !S_AXI_BVALID && !ARESET;
    assign S_AXI_WREADY  = !w_full && !S_AXI_BVALID && !ARESET;
    assign S_AXI_ARREADY = !S_AXI_RVALID && !ARESET;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_full && w_full && !S_AXI_BVALID;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], aw_addr_q[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                if (in_range(aw_addr_q)) begin
                    S_AXI_BRESP <= RESP_OKAY;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs[aw_addr_q[3:2]][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end else begin
                    S_AXI_BRESP <= RESP_SLVERR;
                end
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            // Non-blocking read of regs yields the pre-commit value on a same-edge collision.
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                if (in_range(S_AXI_ARADDR)) begin
                    S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
                    S_AXI_RRESP <= RESP_OKAY;
                end else begin
                    S_AXI_RDATA <= '0;
                    S_AXI_RRESP <= RESP_SLVERR;
                end
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_myddr_axil_slave.sv
// tb/tb_myddr_axil_slave.sv - self-checking bench for myddr_axil_slave
module tb_myddr_axil_slave;

    logic        ACLK;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    myddr_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] model [4];
    int          total = 0;
    int          bad = 0;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: out-of-window addresses error and change nothing; otherwise merge strobed bytes.
    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a >= 5'h10) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read_data(input logic [4:0] a);
        return (a >= 5'h10) ? 32'h0 : model[a / 4];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        S_AXI_AWADDR = a;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            #0;
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 32'h0, 32'h1);
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!S_AXI_BVALID) check("bvalid_timeout", 32'h0, 32'h1);
        repeat (b_dly) tick();
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] resp);
        int cyc = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!S_AXI_ARREADY) check("arready_timeout", 32'h0, 32'h1);
        tick();
        S_AXI_ARVALID = 1'b0;
        check("rvalid_next_cycle", {31'h0, S_AXI_RVALID}, 32'h1);
        repeat (r_dly) tick();
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          rd_seen;

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        vecs[0]  = '{1'b1, 5'h00, 32'h1,        4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b1, 5'h04, 32'h2,        4'hF, 32'h0,        2'b00};
        vecs[2]  = '{1'b1, 5'h08, 32'h3,        4'hF, 32'h0,        2'b00};
        vecs[3]  = '{1'b1, 5'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
        vecs[4]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h1,        2'b00};
        vecs[5]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h2,        2'b00};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h3,        2'b00};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
        vecs[8]  = '{1'b1, 5'h00, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h00BB00DD, 2'b00};
        vecs[10] = '{1'b1, 5'h14, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10};
        vecs[11] = '{1'b0, 5'h10, 32'h0,        4'h0, 32'h0,        2'b10};
        vecs[12] = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h00BB00DD, 2'b00};
        vecs[13] = '{1'b0, 5'h05, 32'h0,        4'h0, 32'h2,        2'b00};
        vecs[14] = '{1'b0, 5'h0B, 32'h0,        4'h0, 32'h3,        2'b00};
        vecs[15] = '{1'b1, 5'h0D, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00};
        vecs[16] = '{1'b0, 5'h0E, 32'h0,        4'h0, 32'h4,        2'b00};

        tick();
        tick();
        check("rst_awready", {31'h0, S_AXI_AWREADY}, 32'h0);
        check("rst_wready",  {31'h0, S_AXI_WREADY},  32'h0);
        check("rst_arready", {31'h0, S_AXI_ARREADY}, 32'h0);
        check("rst_bvalid",  {31'h0, S_AXI_BVALID},  32'h0);
        check("rst_rvalid",  {31'h0, S_AXI_RVALID},  32'h0);
        check("rst_resps",   {28'h0, S_AXI_BRESP, S_AXI_RRESP}, 32'h0);
        check("rst_rdata",   S_AXI_RDATA, 32'h0);
        ARESET = 1'b0;
        #1;
        check("post_rst_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rsp);
                check($sformatf("vec%0d_bresp", i), {30'h0, rsp}, {30'h0, vecs[i].exp_resp});
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
            end else begin
                do_read(vecs[i].addr, 0, rd, rsp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), {30'h0, rsp}, {30'h0, vecs[i].exp_resp});
            end
        end

        // W leads AW by three cycles.
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        repeat (2) begin
            check("wlead_wready_low", {31'h0, S_AXI_WREADY}, 32'h0);
            check("wlead_awready_high", {31'h0, S_AXI_AWREADY}, 32'h1);
            tick();
        end
        check("wlead_wready_low", {31'h0, S_AXI_WREADY}, 32'h0);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wlead_bvalid_t1", {31'h0, S_AXI_BVALID}, 32'h0);
        check("wlead_awready_t1", {31'h0, S_AXI_AWREADY}, 32'h0);
        tick();
        check("wlead_bvalid_t2", {31'h0, S_AXI_BVALID}, 32'h1);
        check("wlead_readys_t2", {30'h0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
        check("wlead_bresp", {30'h0, S_AXI_BRESP}, 32'h0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        void'(model_write(5'h08, 32'h12345678, 4'hF));
        do_read(5'h08, 0, rd, rsp);
        check("wlead_reg2", rd, 32'h12345678);

        // BREADY stalled five cycles while a read completes alongside.
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        check("stall_bvalid_up", {31'h0, S_AXI_BVALID}, 32'h1);
        void'(model_write(5'h04, 32'hCAFEF00D, 4'hF));
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
            check("stall_bresp", {30'h0, S_AXI_BRESP}, 32'h0);
            check("stall_aw_w_ready", {30'h0, S_AXI_AWREADY, S_AXI_WREADY}, 32'h0);
            if (S_AXI_RVALID) begin
                rd_seen++;
                check("stall_rdata", S_AXI_RDATA, model[3]);
            end
            tick();
            S_AXI_ARVALID = 1'b0;
        end
        S_AXI_RREADY = 1'b0;
        check("stall_read_done", rd_seen, 32'h1);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        check("stall_bvalid_clear", {31'h0, S_AXI_BVALID}, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a = a & 5'h0F;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                logic [1:0] exp_rsp;
                exp_rsp = model_write(a, d, s);
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), rsp);
                check("rand_bresp", {30'h0, rsp}, {30'h0, exp_rsp});
            end else begin
                do_read(a, $urandom_range(0, 2), rd, rsp);
                check("rand_rdata", rd, model_read_data(a));
                check("rand_rresp", {30'h0, rsp}, (a >= 5'h10) ? 32'h2 : 32'h0);
            end
        end

        // One-cycle reset while both response channels hold VALID.
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55AA55AA; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick();
        check("prerst_valids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        #1;
        check("rst_pulse_valids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        check("rst_pulse_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            do_read(5'(i * 4), 0, rd, rsp);
            check($sformatf("rst_pulse_reg%0d", i), rd, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
